pipe_hazard_ctrl: RTL

//   Sequencing controller for the decode stage and the EX/MEM/WB stages behind it.

---
 rtl/pipe_hazard_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Decode/EX/MEM/WB sequencing controller.
// Tracks in-flight register writers in a three-entry scoreboard and derives
// forwarding selects, load-use stalls, memory-busy freezes and PC redirects.
// Handshake: there is no valid/ready pair here; dec_valid qualifies the decode
// slot, and stage_en=1 is the single "advance" strobe for EX/MEM/WB and the
// scoreboard, while pc_hold=1 freezes PC and IF/ID in the same cycle.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic             dec_use_rs,
  input  logic             dec_use_rt,
  input  logic             dec_write_reg,
  input  logic             dec_load,
  input  logic [4:0]       dec_reg_address,
  input  logic             dec_cancel,
  input  logic             dec_jump,
  input  logic             mem_busy,
  output logic             dec_enable,
  output logic             pc_hold,
  output logic [1:0]       pc_sel,
  output logic             if_flush,
  output logic             stage_en,
  output logic             ex_valid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             state_dbg_o
);

  typedef struct packed {
    logic       v;
    logic [4:0] addr;
    logic       ld;
  } sb_entry_t;

  typedef enum logic {RUN = 1'b0, BR = 1'b1} state_t;

  state_t           state_q, state_d;
  sb_entry_t        ex_q, mem_q, wb_q, new_entry;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             lu;

  // Youngest-first source select; a load still in EX cannot forward its data.
  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input sb_entry_t ex, input sb_entry_t mem,
                                         input sb_entry_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_r && (r != 5'd0)) begin
      if (ex.v && !ex.ld && (ex.addr == r))  sel = 2'b01;
      else if (mem.v && (mem.addr == r))     sel = 2'b10;
      else if (wb.v && (wb.addr == r))       sel = 2'b11;
    end
    return sel;
  endfunction

  // Forwarding selects and the load-use hazard against the EX entry.
  always_comb begin
    fwd_a = fwd_sel(dec_use_rs, dec_rs, ex_q, mem_q, wb_q);
    fwd_b = fwd_sel(dec_use_rt, dec_rt, ex_q, mem_q, wb_q);
    lu    = dec_valid && ex_q.v && ex_q.ld &&
            ((dec_use_rs && (dec_rs == ex_q.addr)) ||
             (dec_use_rt && (dec_rt == ex_q.addr)));
  end

  // Control outputs and next state; mem_busy freezes everything, then BR, lu, jump, cancel.
  always_comb begin
    state_d    = state_q;
    dec_enable = 1'b1;
    pc_hold    = 1'b0;
    pc_sel     = 2'b00;
    if_flush   = 1'b0;
    stage_en   = 1'b1;
    ex_valid   = dec_valid;
    if (mem_busy) begin
      stage_en   = 1'b0;
      pc_hold    = 1'b1;
      dec_enable = 1'b0;
      ex_valid   = 1'b0;
    end else if (state_q == BR) begin
      pc_sel     = 2'b10;
      if_flush   = 1'b1;
      dec_enable = 1'b0;
      ex_valid   = 1'b0;
      state_d    = RUN;
    end else if (lu) begin
      pc_hold    = 1'b1;
      dec_enable = 1'b0;
      ex_valid   = 1'b0;
    end else if (dec_valid && dec_jump) begin
      pc_hold    = 1'b1;
      state_d    = BR;
    end else if (dec_valid && dec_cancel) begin
      pc_sel     = 2'b01;
      if_flush   = 1'b1;
    end
  end

  // Entry describing the instruction entering EX this cycle.
  always_comb begin
    new_entry.v    = ex_valid && (dec_write_reg || dec_load) && (dec_reg_address != 5'd0);
    new_entry.addr = dec_reg_address;
    new_entry.ld   = dec_load;
  end

  // Saturating count of held cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_hold && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Scoreboard shifts with the pipeline and freezes with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (stage_en) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= new_entry;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt   = stall_cnt_q;
  assign state_dbg_o = (state_q == BR);

endmodule
